// File: rtl/result_drain_unit.sv
// Drains a captured set of four accumulator words as requantized, saturated elements,
// one per downstream handshake, with sticky drop and saturation statistics.
module result_drain_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 4 * DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic [RES_WIDTH-1:0]  Cell_Output_data_0,
  input  logic [RES_WIDTH-1:0]  Cell_Output_data_1,
  input  logic [RES_WIDTH-1:0]  Cell_Output_data_2,
  input  logic [RES_WIDTH-1:0]  Cell_Output_data_3,
  input  logic                  Result_valid,
  output logic                  Result_ready,
  input  logic [4:0]            Shift,
  input  logic                  Relu_en,
  input  logic                  Clear_stats,
  output logic [DATA_WIDTH-1:0] Out_data,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [1:0]            Out_index,
  output logic                  Out_last,
  output logic                  Drop_err,
  output logic [15:0]           Sat_cnt,
  output logic                  dbg_state
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic signed [RES_WIDTH:0] MAX_V =
    {{(RES_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RES_WIDTH:0] MIN_V =
    {{(RES_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t               state;
  logic [RES_WIDTH-1:0] word_buf [4];
  logic [4:0]           shift_r;
  logic                 relu_r;

  logic [RES_WIDTH-1:0]     word_sel;
  logic signed [RES_WIDTH:0] x_ext, rnd, sum, y_sh, y_relu;
  logic                      sat_hit;
  logic                      capture, out_hs;

  // Both sides use valid/ready: a transfer happens on any rising edge where valid and
  // ready are both high; valid never depends on ready, and a held-off output stays stable.
  assign Result_ready = (state == IDLE) || ((Out_index == 2'd3) && Out_ready);
  assign capture      = Result_valid && Result_ready;
  assign out_hs       = Out_valid && Out_ready;
  assign dbg_state    = state;

  // Round-half-up shift at one extra bit so the rounding add can never wrap.
  always_comb begin
    word_sel = word_buf[Out_index];
    x_ext    = {word_sel[RES_WIDTH-1], word_sel};
    rnd      = '0;
    if (shift_r != 5'd0) rnd = {{RES_WIDTH{1'b0}}, 1'b1} << (shift_r - 5'd1);
    sum      = x_ext + rnd;
    y_sh     = sum >>> shift_r;
    y_relu   = (relu_r && (y_sh < 0)) ? '0 : y_sh;
    sat_hit  = 1'b0;
    Out_data = y_relu[DATA_WIDTH-1:0];
    if (y_relu > MAX_V) begin
      sat_hit  = 1'b1;
      Out_data = MAX_V[DATA_WIDTH-1:0];
    end else if (y_relu < MIN_V) begin
      sat_hit  = 1'b1;
      Out_data = MIN_V[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      Out_valid <= 1'b0;
      Out_index <= 2'd0;
      Out_last  <= 1'b0;
      shift_r   <= 5'd0;
      relu_r    <= 1'b0;
      Drop_err  <= 1'b0;
      Sat_cnt   <= 16'd0;
      for (int i = 0; i < 4; i++) word_buf[i] <= '0;
    end else begin
      if (capture) begin
        word_buf[0] <= Cell_Output_data_0;
        word_buf[1] <= Cell_Output_data_1;
        word_buf[2] <= Cell_Output_data_2;
        word_buf[3] <= Cell_Output_data_3;
        shift_r     <= Shift;
        relu_r      <= Relu_en;
        state       <= DRAIN;
        Out_valid   <= 1'b1;
        Out_index   <= 2'd0;
        Out_last    <= 1'b0;
      end else if (out_hs) begin
        if (Out_index == 2'd3) begin
          state     <= IDLE;
          Out_valid <= 1'b0;
          Out_index <= 2'd0;
          Out_last  <= 1'b0;
        end else begin
          Out_index <= Out_index + 2'd1;
          Out_last  <= (Out_index == 2'd2);
        end
      end

      // Clearing wins over a same-cycle drop or saturation event.
      if (Clear_stats) begin
        Drop_err <= 1'b0;
        Sat_cnt  <= 16'd0;
      end else begin
        if (Result_valid && !Result_ready) Drop_err <= 1'b1;
        if (out_hs && sat_hit && (Sat_cnt != 16'hFFFF)) Sat_cnt <= Sat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_result_drain_unit.sv
// Bench for result_drain_unit: directed scenarios plus random traffic, all outputs
// checked at the falling edge against a queue-based reference model.
module tb_result_drain_unit;

  logic        Clk = 1'b0;
  logic        rst;
  logic [31:0] words [4];
  logic        Result_valid, Result_ready;
  logic [4:0]  Shift;
  logic        Relu_en, Clear_stats;
  logic [7:0]  Out_data;
  logic        Out_valid, Out_ready;
  logic [1:0]  Out_index;
  logic        Out_last, Drop_err;
  logic [15:0] Sat_cnt;
  logic        dbg_state;

  result_drain_unit #(.DATA_WIDTH(8), .RES_WIDTH(32)) dut (
    .Clk(Clk), .rst(rst),
    .Cell_Output_data_0(words[0]), .Cell_Output_data_1(words[1]),
    .Cell_Output_data_2(words[2]), .Cell_Output_data_3(words[3]),
    .Result_valid(Result_valid), .Result_ready(Result_ready),
    .Shift(Shift), .Relu_en(Relu_en), .Clear_stats(Clear_stats),
    .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_index(Out_index), .Out_last(Out_last),
    .Drop_err(Drop_err), .Sat_cnt(Sat_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;
  int fail_prints = 0;

  // Expected elements of the set being drained: {sat, last, index, data}.
  logic [11:0] exp_q [$];
  logic [9:0]  obs_q [$];
  logic [15:0] exp_sat = 16'd0;
  logic        exp_drop = 1'b0;
  int          cap_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      if (fail_prints < 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      fail_prints++;
    end
  endtask

  // Reference: signed arithmetic with explicit floor division, then ReLU, then clipping.
  function automatic logic [11:0] model_elem(input logic [31:0] w, input logic [4:0] s,
                                             input logic relu, input logic [1:0] idx);
    longint x, d, n, y;
    logic   sat;
    x = longint'($signed(w));
    if (s == 5'd0) y = x;
    else begin
      d = longint'(1) << s;
      n = x + d / 2;
      y = n / d;
      if ((n % d) != 0 && n < 0) y = y - 1;
    end
    if (relu && y < 0) y = 0;
    sat = 1'b0;
    if (y > 127) begin y = 127; sat = 1'b1; end
    else if (y < -128) begin y = -128; sat = 1'b1; end
    return {sat, (idx == 2'd3), idx, y[7:0]};
  endfunction

  // Scoreboard / monitor
  always @(negedge Clk) begin : monitor
    logic        ready_exp;
    logic [11:0] e;
    if (rst) begin
      exp_q.delete();
      exp_sat  = 16'd0;
      exp_drop = 1'b0;
    end else begin
      ready_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && Out_ready);
      chk("result_ready", 32'(Result_ready), 32'(ready_exp));
      chk("out_valid", 32'(Out_valid), 32'(exp_q.size() != 0));
      chk("sat_cnt", 32'(Sat_cnt), 32'(exp_sat));
      chk("drop_err", 32'(Drop_err), 32'(exp_drop));
      if (Out_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_data", 32'(Out_data), 32'(e[7:0]));
        chk("out_index", 32'(Out_index), 32'(e[9:8]));
        chk("out_last", 32'(Out_last), 32'(e[10]));
        if (Out_ready) begin
          void'(exp_q.pop_front());
          obs_q.push_back({Out_index, Out_data});
          if (e[11] && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
        end
      end
      if (Result_valid && !ready_exp) exp_drop = 1'b1;
      if (Result_valid && ready_exp) begin
        cap_cnt++;
        for (int i = 0; i < 4; i++)
          exp_q.push_back(model_elem(words[i], Shift, Relu_en, 2'(i)));
      end
      if (Clear_stats) begin
        exp_sat  = 16'd0;
        exp_drop = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic [4:0] s, input logic r);
    int g = 0;
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    Shift = s; Relu_en = r; Result_valid = 1'b1;
    forever begin
      @(negedge Clk);
      if (Result_ready || g >= 50) break;
      g++;
    end
    chk("offer_timeout", 32'(g < 50), 32'd1);
    tick();
    Result_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    chk("drain_timeout", 32'(g < 300), 32'd1);
    tick();
  endtask

  task automatic wait_index(input logic [1:0] idx);
    int g = 0;
    while (Out_index != idx && g < 50) begin
      tick();
      g++;
    end
    chk("index_timeout", 32'(g < 50), 32'd1);
  endtask

  logic [7:0] t1_exp [4];
  logic [7:0] held_d;
  int         start_caps;

  initial begin
    t1_exp = '{8'd100, 8'h9C, 8'd127, 8'h80};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) words[i] = 32'd0;
    Result_valid = 1'b0; Shift = 5'd0; Relu_en = 1'b0; Clear_stats = 1'b0; Out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_out_data", 32'(Out_data), 32'd0);
    chk("rst_out_index", 32'(Out_index), 32'd0);
    chk("rst_out_last", 32'(Out_last), 32'd0);
    chk("rst_sat_cnt", 32'(Sat_cnt), 32'd0);
    chk("rst_drop_err", 32'(Drop_err), 32'd0);
    chk("rst_result_ready", 32'(Result_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Saturating elements, no shift
    obs_q.delete();
    offer(100, -100, 300, -300, 5'd0, 1'b0);
    chk("t1_latency", 32'(Out_valid), 32'd1);
    wait_idle();
    chk("t1_count", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk("t1_data", 32'(obs_q[i][7:0]), 32'(t1_exp[i]));
      chk("t1_index", 32'(obs_q[i][9:8]), 32'(i));
    end
    chk("t1_sat_cnt", 32'(Sat_cnt), 32'd2);

    // Rounding shift and ReLU
    obs_q.delete();
    offer(6, 0, 0, 0, 5'd2, 1'b0);
    offer(-6, 0, 0, 0, 5'd2, 1'b0);
    offer(-6, 0, 0, 0, 5'd2, 1'b1);
    wait_idle();
    chk("t2_count", 32'(obs_q.size()), 32'd12);
    if (obs_q.size() == 12) begin
      chk("t2_pos", 32'(obs_q[0][7:0]), 32'h02);
      chk("t2_neg", 32'(obs_q[4][7:0]), 32'hFF);
      chk("t2_relu", 32'(obs_q[8][7:0]), 32'h00);
    end
    chk("t2_sat_cnt", 32'(Sat_cnt), 32'd2);

    // Backpressure at index 1 with a dropped offer
    obs_q.delete();
    offer(10, 20, 30, 40, 5'd0, 1'b0);
    wait_index(2'd1);
    Out_ready = 1'b0;
    held_d = Out_data;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        for (int i = 0; i < 4; i++) words[i] = 32'd99;
        Result_valid = 1'b1;
      end
      tick();
      Result_valid = 1'b0;
      chk("t3_hold_data", 32'(Out_data), 32'(held_d));
      chk("t3_hold_index", 32'(Out_index), 32'd1);
    end
    Out_ready = 1'b1;
    wait_idle();
    chk("t3_drop_err", 32'(Drop_err), 32'd1);
    chk("t3_count", 32'(obs_q.size()), 32'd4);
    Clear_stats = 1'b1;
    tick();
    Clear_stats = 1'b0;
    chk("t3_clear_drop", 32'(Drop_err), 32'd0);
    chk("t3_clear_sat", 32'(Sat_cnt), 32'd0);

    // Back-to-back sets
    obs_q.delete();
    words = '{32'd1, 32'd2, 32'd3, 32'd4};
    Shift = 5'd0; Relu_en = 1'b0; Result_valid = 1'b1;
    start_caps = cap_cnt;
    for (int g = 0; g < 50 && cap_cnt < start_caps + 2; g++) tick();
    Result_valid = 1'b0;
    wait_idle();
    chk("t4_count", 32'(obs_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      chk("t4_index", 32'(obs_q[i][9:8]), 32'(i % 4));

    // Reset mid-drain
    offer(5, 6, 7, 8, 5'd0, 1'b0);
    wait_index(2'd2);
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 32'(Out_valid), 32'd0);
    chk("t5_out_data", 32'(Out_data), 32'd0);
    chk("t5_out_index", 32'(Out_index), 32'd0);
    chk("t5_out_last", 32'(Out_last), 32'd0);
    @(negedge Clk);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_ready_after", 32'(Result_ready), 32'd1);
    obs_q.delete();
    offer(9, 10, 11, 12, 5'd0, 1'b0);
    wait_idle();
    chk("t5_count", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() != 0) chk("t5_first_index", 32'(obs_q[0][9:8]), 32'd0);

    // Drive the saturation counter to its ceiling
    words = '{32'd1000, 32'd1000, 32'd1000, 32'd1000};
    Shift = 5'd0; Relu_en = 1'b0; Out_ready = 1'b1; Result_valid = 1'b1;
    repeat (65540) tick();
    Result_valid = 1'b0;
    wait_idle();
    chk("t6_sat_max", 32'(Sat_cnt), 32'hFFFF);
    offer(1000, 1000, 1000, 1000, 5'd0, 1'b0);
    wait_idle();
    chk("t6_sat_hold", 32'(Sat_cnt), 32'hFFFF);
    Clear_stats = 1'b1;
    tick();
    Clear_stats = 1'b0;
    chk("t6_sat_clear", 32'(Sat_cnt), 32'd0);

    // Random traffic
    repeat (2000) begin
      Result_valid = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 4; i++)
        words[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 600) - 300;
      Shift       = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      Relu_en     = ($urandom_range(0, 1) == 1);
      Out_ready   = ($urandom_range(0, 3) != 0);
      Clear_stats = ($urandom_range(0, 60) == 0);
      tick();
    end
    Result_valid = 1'b0; Clear_stats = 1'b0; Out_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
